// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings for the MIPS hazard unit: forward-select codes and MDU tracker states.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of pipeline-status inputs and stall/forward/counter outputs between datapath and hazard unit.
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2,
  parameter int CNT_W      = 16
);
  logic                  BranchD;
  logic                  JumpD;
  logic                  MdUseD;
  logic [REG_ADDR_W-1:0] RsD;
  logic [REG_ADDR_W-1:0] RtD;
  logic [REG_ADDR_W-1:0] RsE;
  logic [REG_ADDR_W-1:0] RtE;
  logic [REG_ADDR_W-1:0] WriteRegE;
  logic                  RegWriteE;
  logic                  MemtoRegE;
  logic                  MdStartE;
  logic [REG_ADDR_W-1:0] WriteRegM;
  logic                  RegWriteM;
  logic                  MemtoRegM;
  logic [REG_ADDR_W-1:0] WriteRegW;
  logic                  RegWriteW;
  logic                  CntClr;

  logic [FWD_W-1:0]      ForwardAE;
  logic [FWD_W-1:0]      ForwardBE;
  logic                  ForwardAD;
  logic                  ForwardBD;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushE;
  logic                  MdBusy;
  logic [CNT_W-1:0]      StallCnt;
  logic [CNT_W-1:0]      FlushCnt;

  modport master (
    output BranchD, JumpD, MdUseD, RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
           MdStartE, WriteRegM, RegWriteM, MemtoRegM, WriteRegW, RegWriteW, CntClr,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy,
           StallCnt, FlushCnt
  );

  modport slave (
    input  BranchD, JumpD, MdUseD, RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
           MdStartE, WriteRegM, RegWriteM, MemtoRegM, WriteRegW, RegWriteW, CntClr,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy,
           StallCnt, FlushCnt
  );

endinterface

// File: rtl/hazard_ctrl_unit_md_busy_tracker.sv
// Tracks the multi-cycle multiply/divide unit: busy for MD_LATENCY cycles after each issue.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int MD_CNT_W   = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic MdStartE,
  output logic MdBusy
);

  md_state_t           r_state;
  md_state_t           w_stateNext;
  logic [MD_CNT_W-1:0] r_mdCnt;
  logic [MD_CNT_W-1:0] w_mdCntNext;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= MD_IDLE;
      r_mdCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      r_mdCnt <= w_mdCntNext;
    end
  end

  // A new issue while busy restarts the full latency rather than queueing.
  always_comb begin
    w_stateNext = r_state;
    w_mdCntNext = r_mdCnt;
    case (r_state)
      MD_IDLE: begin
        if (MdStartE) begin
          w_stateNext = MD_BUSY;
          w_mdCntNext = MD_CNT_W'(MD_LATENCY);
        end
      end
      MD_BUSY: begin
        if (MdStartE) begin
          w_mdCntNext = MD_CNT_W'(MD_LATENCY);
        end else if (r_mdCnt == MD_CNT_W'(1)) begin
          w_stateNext = MD_IDLE;
          w_mdCntNext = '0;
        end else begin
          w_mdCntNext = r_mdCnt - MD_CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = MD_IDLE;
        w_mdCntNext = '0;
      end
    endcase
  end

  assign MdBusy = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use/branch/MDU stalls,
// jump flush and saturating stall/flush performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2,
  parameter int MD_LATENCY = 4,
  parameter int MD_CNT_W   = 3,
  parameter int CNT_W      = 16
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_ctrl_unit_if.slave hz
);

  logic             w_lwStall;
  logic             w_branchStall;
  logic             w_mdStall;
  logic             w_stall;
  logic             w_flush;
  logic             w_mdBusy;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  function automatic logic srcHit(input logic [REG_ADDR_W-1:0] src,
                                  input logic [REG_ADDR_W-1:0] dst,
                                  input logic                  we);
    return (src != '0) && (src == dst) && we;
  endfunction

  function automatic logic [FWD_W-1:0] fwdSel(input logic [REG_ADDR_W-1:0] src);
    if (srcHit(src, hz.WriteRegM, hz.RegWriteM))      return FWD_W'(FWD_MEM);
    else if (srcHit(src, hz.WriteRegW, hz.RegWriteW)) return FWD_W'(FWD_WB);
    else                                              return FWD_W'(FWD_NONE);
  endfunction

  md_busy_tracker #(
    .MD_LATENCY (MD_LATENCY),
    .MD_CNT_W   (MD_CNT_W)
  ) u_mdBusyTracker (
    .CLK      (CLK),
    .RST      (RST),
    .MdStartE (hz.MdStartE),
    .MdBusy   (w_mdBusy)
  );

  assign hz.ForwardAE = fwdSel(hz.RsE);
  assign hz.ForwardBE = fwdSel(hz.RtE);
  assign hz.ForwardAD = srcHit(hz.RsD, hz.WriteRegM, hz.RegWriteM);
  assign hz.ForwardBD = srcHit(hz.RtD, hz.WriteRegM, hz.RegWriteM);

  assign w_lwStall = hz.MemtoRegE && (hz.RtE != '0) &&
                     ((hz.RsD == hz.RtE) || (hz.RtD == hz.RtE));

  // A branch resolved in D cannot take an E-stage result or an M-stage load value yet.
  assign w_branchStall = hz.BranchD &&
    ((hz.RegWriteE && (hz.WriteRegE != '0) &&
      ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
     (hz.MemtoRegM && (hz.WriteRegM != '0) &&
      ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));

  assign w_mdStall = hz.MdUseD && (w_mdBusy || hz.MdStartE);
  assign w_stall   = w_lwStall | w_branchStall | w_mdStall;
  assign w_flush   = w_stall | hz.JumpD;

  assign hz.StallF   = w_stall;
  assign hz.StallD   = w_stall;
  assign hz.FlushE   = w_flush;
  assign hz.MdBusy   = w_mdBusy;
  assign hz.StallCnt = r_stallCnt;
  assign hz.FlushCnt = r_flushCnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else if (hz.CntClr) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_flush && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit (CNT_W=4 so counter saturation is reachable).
module tb_hazard_ctrl_unit;

  typedef enum {kFae, kFbe, kFad, kFbd, kStallF, kStallD, kFlushE, kBusy, kSCnt, kFCnt} kind_t;
  typedef struct {
    kind_t kind;
    int    val;
    string name;
  } exp_t;

  logic  clk;
  logic  rstN;
  exp_t  expQ[$];
  int    nChecks;
  int    nFail;

  hazard_ctrl_unit_if #(.REG_ADDR_W(5), .FWD_W(2), .CNT_W(4)) hzIf ();

  hazard_ctrl_unit #(
    .REG_ADDR_W (5),
    .FWD_W      (2),
    .MD_LATENCY (4),
    .MD_CNT_W   (3),
    .CNT_W      (4)
  ) dut (
    .CLK (clk),
    .RST (rstN),
    .hz  (hzIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each vector starts from a quiet pipeline one time unit after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    hzIf.BranchD   = 1'b0;
    hzIf.JumpD     = 1'b0;
    hzIf.MdUseD    = 1'b0;
    hzIf.RsD       = '0;
    hzIf.RtD       = '0;
    hzIf.RsE       = '0;
    hzIf.RtE       = '0;
    hzIf.WriteRegE = '0;
    hzIf.RegWriteE = 1'b0;
    hzIf.MemtoRegE = 1'b0;
    hzIf.MdStartE  = 1'b0;
    hzIf.WriteRegM = '0;
    hzIf.RegWriteM = 1'b0;
    hzIf.MemtoRegM = 1'b0;
    hzIf.WriteRegW = '0;
    hzIf.RegWriteW = 1'b0;
    hzIf.CntClr    = 1'b0;
  endtask

  task automatic expectOut(input kind_t k, input int v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    int act;
    case (e.kind)
      kFae:    act = int'(hzIf.ForwardAE);
      kFbe:    act = int'(hzIf.ForwardBE);
      kFad:    act = int'(hzIf.ForwardAD);
      kFbd:    act = int'(hzIf.ForwardBD);
      kStallF: act = int'(hzIf.StallF);
      kStallD: act = int'(hzIf.StallD);
      kFlushE: act = int'(hzIf.FlushE);
      kBusy:   act = int'(hzIf.MdBusy);
      kSCnt:   act = int'(hzIf.StallCnt);
      default: act = int'(hzIf.FlushCnt);
    endcase
    nChecks++;
    if (act !== e.val) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", e.name, act, e.val);
    end
  endtask

  // Monitor: drains every pending expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0;
    nFail   = 0;
    rstN    = 1'b0;

    applyStimulus();
    expectOut(kBusy, 0, "reset_busy");
    expectOut(kSCnt, 0, "reset_stallcnt");
    expectOut(kFCnt, 0, "reset_flushcnt");
    expectOut(kStallD, 0, "reset_stalld");
    expectOut(kFlushE, 0, "reset_flushe");

    // Forwarding priority M over W, then register zero never forwards
    applyStimulus();
    rstN = 1'b1;
    hzIf.RsE = 5'd3; hzIf.RtE = 5'd3; hzIf.RsD = 5'd3;
    hzIf.WriteRegM = 5'd3; hzIf.RegWriteM = 1'b1;
    hzIf.WriteRegW = 5'd3; hzIf.RegWriteW = 1'b1;
    expectOut(kFae, 2, "fwd_ae_mem");
    expectOut(kFbe, 2, "fwd_be_mem");
    expectOut(kFad, 1, "fwd_ad_mem");
    expectOut(kStallD, 0, "fwd_no_stall");

    applyStimulus();
    hzIf.RsE = 5'd3; hzIf.RtE = 5'd3; hzIf.RsD = 5'd3;
    hzIf.WriteRegM = 5'd3; hzIf.WriteRegW = 5'd3; hzIf.RegWriteW = 1'b1;
    expectOut(kFae, 1, "fwd_ae_wb");
    expectOut(kFbe, 1, "fwd_be_wb");
    expectOut(kFad, 0, "fwd_ad_off");

    applyStimulus();
    hzIf.RtE = 5'd3;
    hzIf.WriteRegW = 5'd3; hzIf.RegWriteW = 1'b1;
    expectOut(kFae, 0, "fwd_ae_r0");
    expectOut(kFbe, 1, "fwd_be_wb_only");

    // Load-use stall
    applyStimulus();
    hzIf.MemtoRegE = 1'b1; hzIf.RtE = 5'd5; hzIf.RsD = 5'd5;
    expectOut(kStallF, 1, "lw_stallf");
    expectOut(kStallD, 1, "lw_stalld");
    expectOut(kFlushE, 1, "lw_flushe");
    expectOut(kSCnt, 0, "lw_cnt_before");

    applyStimulus();
    expectOut(kStallD, 0, "lw_released");
    expectOut(kSCnt, 1, "lw_stallcnt");
    expectOut(kFCnt, 1, "lw_flushcnt");

    applyStimulus();
    hzIf.MemtoRegE = 1'b1;
    expectOut(kStallD, 0, "lw_rt0_nostall");
    expectOut(kFlushE, 0, "lw_rt0_noflush");

    // Branch hazards: ALU producer in E, then in M (forward), then load in M
    applyStimulus();
    hzIf.BranchD = 1'b1; hzIf.RsD = 5'd7;
    hzIf.RegWriteE = 1'b1; hzIf.WriteRegE = 5'd7;
    expectOut(kStallD, 1, "br_e_stall");
    expectOut(kFad, 0, "br_e_nofwd");
    expectOut(kSCnt, 1, "br_cnt1");

    applyStimulus();
    hzIf.BranchD = 1'b1; hzIf.RsD = 5'd7; hzIf.RtD = 5'd7;
    hzIf.WriteRegM = 5'd7; hzIf.RegWriteM = 1'b1;
    expectOut(kFad, 1, "br_m_fwd_a");
    expectOut(kFbd, 1, "br_m_fwd_b");
    expectOut(kStallD, 0, "br_m_nostall");
    expectOut(kSCnt, 2, "br_cnt2");

    applyStimulus();
    hzIf.BranchD = 1'b1; hzIf.RsD = 5'd7; hzIf.RtD = 5'd7;
    hzIf.WriteRegM = 5'd7; hzIf.RegWriteM = 1'b1; hzIf.MemtoRegM = 1'b1;
    expectOut(kStallD, 1, "br_load_stall");
    expectOut(kFlushE, 1, "br_load_flush");

    // Jump flushes without stalling
    applyStimulus();
    hzIf.JumpD = 1'b1;
    expectOut(kFlushE, 1, "jump_flushe");
    expectOut(kStallF, 0, "jump_stallf");
    expectOut(kStallD, 0, "jump_stalld");
    expectOut(kSCnt, 3, "jump_scnt");
    expectOut(kFCnt, 3, "jump_fcnt_before");

    applyStimulus();
    expectOut(kFCnt, 4, "jump_fcnt_after");
    expectOut(kFlushE, 0, "jump_done");

    // MDU: issue cycle plus four busy cycles stall a HI/LO user
    applyStimulus();
    hzIf.MdStartE = 1'b1; hzIf.MdUseD = 1'b1;
    expectOut(kStallD, 1, "md_issue_stall");
    expectOut(kBusy, 0, "md_issue_busy");
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      hzIf.MdUseD = 1'b1;
      expectOut(kBusy, 1, $sformatf("md_busy_%0d", i));
      expectOut(kStallD, 1, $sformatf("md_stall_%0d", i));
    end
    applyStimulus();
    hzIf.MdUseD = 1'b1;
    expectOut(kBusy, 0, "md_done_busy");
    expectOut(kStallD, 0, "md_done_stall");
    expectOut(kSCnt, 8, "md_scnt");
    expectOut(kFCnt, 9, "md_fcnt");

    // Asynchronous reset in mid-BUSY, sampled before the next rising edge
    applyStimulus();
    hzIf.MdStartE = 1'b1;
    expectOut(kStallD, 0, "rst_issue_nouse");
    applyStimulus();
    expectOut(kBusy, 1, "rst_pre_busy");
    expectOut(kSCnt, 8, "rst_pre_scnt");
    @(posedge clk);
    #2;
    rstN = 1'b0;
    hzIf.MdStartE = 1'b1; hzIf.MdUseD = 1'b1;
    expectOut(kBusy, 0, "rst_async_busy");
    expectOut(kSCnt, 0, "rst_async_scnt");
    expectOut(kFCnt, 0, "rst_async_fcnt");
    expectOut(kStallD, 1, "rst_mdstart_stall");

    applyStimulus();
    expectOut(kBusy, 0, "rst_held_busy");
    applyStimulus();
    rstN = 1'b1;
    hzIf.MdUseD = 1'b1;
    expectOut(kBusy, 0, "rst_rel_busy");
    expectOut(kStallD, 0, "rst_rel_stall");
    applyStimulus();
    hzIf.MdUseD = 1'b1;
    expectOut(kBusy, 0, "rst_rel_busy2");
    expectOut(kStallD, 0, "rst_rel_stall2");

    // Counter saturation at 15, then clear while stall persists
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      hzIf.MemtoRegE = 1'b1; hzIf.RtE = 5'd5; hzIf.RsD = 5'd5;
      expectOut(kSCnt, (i < 15) ? i : 15, $sformatf("sat_scnt_%0d", i));
      expectOut(kFCnt, (i < 15) ? i : 15, $sformatf("sat_fcnt_%0d", i));
    end
    applyStimulus();
    hzIf.MemtoRegE = 1'b1; hzIf.RtE = 5'd5; hzIf.RsD = 5'd5; hzIf.CntClr = 1'b1;
    expectOut(kSCnt, 15, "clr_pre_scnt");
    expectOut(kStallD, 1, "clr_stall");
    applyStimulus();
    hzIf.MemtoRegE = 1'b1; hzIf.RtE = 5'd5; hzIf.RsD = 5'd5;
    expectOut(kSCnt, 0, "clr_scnt");
    expectOut(kFCnt, 0, "clr_fcnt");
    applyStimulus();
    expectOut(kSCnt, 1, "clr_resume_scnt");

    applyStimulus();
    @(negedge clk);
    #1;
    nChecks++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
